// File: rtl/pid_ctrl_ss.sv
// Purpose: balance PID (saturated error, clamping integrator, selectable D) with soft-start output scaling.
// Latency: vld in cycle n -> PID_cntrl/cntrl_vld in cycle n+2; accepts a new sample every cycle.
// Backpressure: none; the output is a registered value marked by a single-cycle cntrl_vld pulse.
module pid_ctrl_ss #(
   parameter int ERR_W      = 10,
   parameter int INT_W      = 18,
   parameter int OUT_W      = 12,
   parameter int P_COEFF    = 12,
   parameter int I_SHIFT    = 6,
   parameter int DERIV_MODE = 0,
   parameter int D_SHIFT    = 6,
   parameter int D_COEFF    = 2,
   parameter int SS_W       = 27,
   parameter int SS_INC     = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             vld,
   input  logic [15:0]      ptch,
   input  logic [15:0]      ptch_rt,
   input  logic             pwr_up,
   input  logic             rider_off,
   output logic [OUT_W-1:0] PID_cntrl,
   output logic             cntrl_vld,
   output logic [7:0]       ss_tmr,
   output logic             int_sat
);

   // Term widths are chosen so no stage-1 product or the stage-2 sum can wrap.
   localparam int P_W  = ERR_W + 7;
   localparam int D_W  = (ERR_W + 6 > 17) ? ERR_W + 6 : 17;
   localparam int M1_W = (P_W > INT_W) ? P_W : INT_W;
   localparam int M2_W = (M1_W > D_W) ? M1_W : D_W;
   localparam int S_W  = M2_W + 2;

   localparam logic [5:0]              P_C       = 6'(P_COEFF);
   localparam logic [3:0]              D_C       = 4'(D_COEFF);
   localparam logic signed [15:0]      ERR_MAX16 = 16'(2**(ERR_W-1) - 1);
   localparam logic signed [15:0]      ERR_MIN16 = 16'(-(2**(ERR_W-1)));
   localparam logic signed [INT_W-1:0] INT_MAX   = {1'b0, {(INT_W-1){1'b1}}};
   localparam logic signed [INT_W-1:0] INT_MIN   = {1'b1, {(INT_W-1){1'b0}}};
   localparam logic signed [OUT_W-1:0] SAT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] SAT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};
   localparam logic [SS_W:0]           SS_STEP   = (SS_W+1)'(SS_INC);

   typedef enum logic [1:0] {OFF = 2'd0, RAMP = 2'd1, RUN = 2'd2} state_t;

   state_t                  state, state_nxt;
   logic [SS_W-1:0]         ss_cnt;
   logic [SS_W:0]           ss_sum;
   logic signed [15:0]      ptch_s;
   logic signed [ERR_W-1:0] err_sat, prev_err;
   logic signed [INT_W-1:0] integ, int_clamp, int_nxt;
   logic signed [INT_W:0]   int_sum;
   logic                    int_ovf;
   logic signed [P_W-1:0]   p_calc, p_reg;
   logic signed [INT_W-1:0] i_calc, i_reg;
   logic signed [16:0]      rt_ext, rt_sh, d0;
   logic signed [ERR_W:0]   diff;
   logic signed [ERR_W+5:0] d1;
   logic signed [D_W-1:0]   d_calc, d_reg;
   logic                    s1_vld;
   logic signed [S_W-1:0]   sum;
   logic signed [OUT_W-1:0] sat, scaled, out_nxt;
   logic signed [OUT_W+8:0] prod;

   assign ptch_s = $signed(ptch);
   assign ss_tmr = ss_cnt[SS_W-1:SS_W-8];
   assign ss_sum = {1'b0, ss_cnt} + SS_STEP;

   // Clip the raw pitch into the error range.
   always_comb begin
      err_sat = ptch_s[ERR_W-1:0];
      if (ptch_s > ERR_MAX16)
         err_sat = ERR_MAX16[ERR_W-1:0];
      else if (ptch_s < ERR_MIN16)
         err_sat = ERR_MIN16[ERR_W-1:0];
   end

   // Integrator candidate: one guard bit detects overflow, then clamp; rider_off wins.
   always_comb begin
      int_sum   = {integ[INT_W-1], integ} + {{(INT_W+1-ERR_W){err_sat[ERR_W-1]}}, err_sat};
      int_ovf   = int_sum[INT_W] ^ int_sum[INT_W-1];
      int_clamp = int_sum[INT_W-1:0];
      if (int_ovf)
         int_clamp = int_sum[INT_W] ? INT_MIN : INT_MAX;
      int_nxt   = rider_off ? '0 : int_clamp;
   end

   // Stage-1 term arithmetic at full precision.
   always_comb begin
      p_calc = err_sat * $signed({1'b0, P_C});
      i_calc = int_nxt >>> I_SHIFT;
      rt_ext = $signed({ptch_rt[15], ptch_rt});
      rt_sh  = rt_ext >>> D_SHIFT;
      d0     = -rt_sh;
      diff   = {prev_err[ERR_W-1], prev_err} - {err_sat[ERR_W-1], err_sat};
      d1     = diff * $signed({1'b0, D_C});
      d_calc = (DERIV_MODE == 1) ? D_W'(d1) : D_W'(d0);
   end

   // Stage-2 sum, saturation and soft-start scaling by the current state.
   always_comb begin
      sum = S_W'(p_reg) + S_W'(i_reg) + S_W'(d_reg);
      sat = sum[OUT_W-1:0];
      if (sum > S_W'(SAT_MAX))
         sat = SAT_MAX;
      else if (sum < S_W'(SAT_MIN))
         sat = SAT_MIN;
      prod   = sat * $signed({1'b0, ss_tmr});
      scaled = OUT_W'(prod >>> 8);
      case (state)
         RAMP:    out_nxt = scaled;
         RUN:     out_nxt = sat;
         default: out_nxt = '0;
      endcase
   end

   // Soft-start sequencer next state; pwr_up low forces OFF from anywhere.
   always_comb begin
      state_nxt = state;
      if (!pwr_up)
         state_nxt = OFF;
      else begin
         case (state)
            OFF:     state_nxt = RAMP;
            RAMP:    if (ss_tmr == 8'hFF) state_nxt = RUN;
            default: state_nxt = state;
         endcase
      end
   end

   // State register and saturating soft-start counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= OFF;
         ss_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (!pwr_up)
            ss_cnt <= '0;
         else if (ss_sum[SS_W])
            ss_cnt <= '1;
         else
            ss_cnt <= ss_sum[SS_W-1:0];
      end
   end

   // Integrator, previous error, clamp flag and stage-1 term registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         integ    <= '0;
         prev_err <= '0;
         int_sat  <= 1'b0;
         p_reg    <= '0;
         i_reg    <= '0;
         d_reg    <= '0;
         s1_vld   <= 1'b0;
      end else begin
         int_sat <= vld & ~rider_off & int_ovf;
         s1_vld  <= vld;
         if (vld) begin
            integ    <= int_nxt;
            prev_err <= err_sat;
            p_reg    <= p_calc;
            i_reg    <= i_calc;
            d_reg    <= d_calc;
         end
      end
   end

   // Output register: loads on stage-1 valid, holds otherwise.
   always_ff @(posedge clk) begin
      if (rst) begin
         PID_cntrl <= '0;
         cntrl_vld <= 1'b0;
      end else begin
         cntrl_vld <= s1_vld;
         if (s1_vld)
            PID_cntrl <= out_nxt;
      end
   end

endmodule

// File: tb/tb_pid_ctrl_ss.sv
// Purpose: directed bench for pid_ctrl_ss; one D-from-rate and one D-from-difference instance share stimulus.
// Latency: outputs sampled 1 time unit after each rising edge, two edges after a sample is presented.
// Backpressure: not applicable; the bench drives vld freely.
module tb_pid_ctrl_ss;

   logic        clk;
   logic        rst;
   logic        vld;
   logic [15:0] ptch;
   logic [15:0] ptch_rt;
   logic        pwr_up;
   logic        rider_off;

   logic [11:0] pid0, pid1;
   logic        cv0, cv1;
   logic [7:0]  tmr0, tmr1;
   logic        isat0, isat1;

   int checks = 0;
   int errors = 0;

   pid_ctrl_ss #(.DERIV_MODE(0), .SS_W(12), .SS_INC(1)) u_dut0 (
      .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
      .pwr_up(pwr_up), .rider_off(rider_off),
      .PID_cntrl(pid0), .cntrl_vld(cv0), .ss_tmr(tmr0), .int_sat(isat0)
   );

   pid_ctrl_ss #(.DERIV_MODE(1), .D_COEFF(2), .SS_W(12), .SS_INC(1)) u_dut1 (
      .clk(clk), .rst(rst), .vld(vld), .ptch(ptch), .ptch_rt(ptch_rt),
      .pwr_up(pwr_up), .rider_off(rider_off),
      .PID_cntrl(pid1), .cntrl_vld(cv1), .ss_tmr(tmr1), .int_sat(isat1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one sample for one edge; returns just after the capture edge.
   task automatic send(input logic [15:0] p, input logic [15:0] r, input logic ro);
      vld       = 1'b1;
      ptch      = p;
      ptch_rt   = r;
      rider_off = ro;
      tick();
      vld       = 1'b0;
      rider_off = 1'b0;
   endtask

   // Send a sample and advance to the edge where its result appears.
   task automatic sample(input logic [15:0] p, input logic [15:0] r, input logic ro);
      send(p, r, ro);
      tick();
   endtask

   task automatic wait_tmr(input string tag, input logic [7:0] target, input int budget);
      int n = 0;
      while (tmr0 !== target && n < budget) begin
         tick();
         n++;
      end
      chk(tag, 32'(tmr0), 32'(target));
   endtask

   initial begin
      int early_sat = 0;
      int late_sat  = 0;

      rst = 1'b1; vld = 1'b0; ptch = '0; ptch_rt = '0; pwr_up = 1'b0; rider_off = 1'b0;
      repeat (3) tick();
      chk("rst_pid0", 32'(pid0), 32'h0);
      chk("rst_cv0", 32'(cv0), 32'h0);
      chk("rst_tmr0", 32'(tmr0), 32'h0);
      chk("rst_isat0", 32'(isat0), 32'h0);
      chk("rst_pid1", 32'(pid1), 32'h0);
      rst = 1'b0;
      tick();

      // Soft-start ramp: level steps every 16 clocks with a 12-bit counter.
      pwr_up = 1'b1;
      repeat (15) tick();
      chk("ss_15", 32'(tmr0), 32'h00);
      tick();
      chk("ss_16", 32'(tmr0), 32'h01);
      repeat (16) tick();
      chk("ss_32", 32'(tmr0), 32'h02);

      // Half-scale ramp: 192 * 128 >> 8 = 96; mode-1 gives 160 -> 80.
      wait_tmr("wait_80", 8'h80, 3000);
      sample(16'h0010, 16'h0000, 1'b0);
      chk("ramp_cv0", 32'(cv0), 32'h1);
      chk("ramp_pid0", 32'(pid0), 32'd96);
      chk("ramp_pid1", 32'(pid1), 32'd80);

      wait_tmr("wait_ff", 8'hFF, 3000);
      repeat (3) tick();

      // Clear integrator, then basic RUN response with 2-cycle latency.
      sample(16'h0000, 16'h0000, 1'b1);
      chk("clr_pid0", 32'(pid0), 32'h0);
      send(16'h0010, 16'h0000, 1'b0);
      chk("lat_cv0_n1", 32'(cv0), 32'h0);
      tick();
      chk("run_cv0", 32'(cv0), 32'h1);
      chk("run_pid0", 32'(pid0), 32'h0C0);
      tick();
      chk("cv0_pulse", 32'(cv0), 32'h0);
      chk("pid0_hold", 32'(pid0), 32'h0C0);

      // Positive and negative full-scale saturation.
      sample(16'h7FFF, 16'h8000, 1'b0);
      chk("sat_pos", 32'(pid0), 32'h7FF);
      sample(16'h0000, 16'h0000, 1'b1);
      sample(16'h8000, 16'h7FFF, 1'b0);
      chk("sat_neg", 32'(pid0), 32'h800);
      sample(16'h0000, 16'h0000, 1'b1);

      // Integrator clamp: 256 samples of -512 land exactly on the minimum.
      vld = 1'b1; ptch = 16'h8000; ptch_rt = 16'h0000;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (k <= 256) early_sat += int'(isat0);
         else          late_sat  += int'(isat0);
         if (k == 256) chk("integ_256", {14'b0, u_dut0.integ}, 32'h20000);
      end
      vld = 1'b0;
      chk("isat_early", 32'(early_sat), 32'd0);
      chk("isat_late", 32'(late_sat), 32'd44);
      chk("integ_300", {14'b0, u_dut0.integ}, 32'h20000);
      sample(16'h0000, 16'h0000, 1'b0);
      chk("i_term_min", 32'(pid0), 32'h800);
      send(16'h8000, 16'h0000, 1'b1);
      chk("ro_isat", 32'(isat0), 32'h0);
      chk("ro_integ", {14'b0, u_dut0.integ}, 32'h0);
      tick();
      chk("ro_pid0", 32'(pid0), 32'h800);

      // Difference-mode D, back-to-back samples: 0 then 192 - 32 = 160.
      sample(16'h0000, 16'h0000, 1'b1);
      vld = 1'b1; ptch = 16'h0000; ptch_rt = 16'h0000;
      tick();
      ptch = 16'h0010;
      tick();
      vld = 1'b0;
      chk("d1_first", 32'(pid1), 32'd0);
      chk("d1_first_cv", 32'(cv1), 32'h1);
      tick();
      chk("d1_second", 32'(pid1), 32'd160);
      chk("d1_second_cv", 32'(cv1), 32'h1);
      chk("d0_second", 32'(pid0), 32'd192);

      // pwr_up drop: counter clears next edge, in-flight sample yields 0 with a pulse.
      pwr_up = 1'b0; vld = 1'b1; ptch = 16'h0010;
      tick();
      vld = 1'b0;
      chk("drop_tmr", 32'(tmr0), 32'h0);
      tick();
      chk("drop_cv0", 32'(cv0), 32'h1);
      chk("drop_pid0", 32'(pid0), 32'h0);

      // Re-ramp to level 4: 192 * 4 >> 8 = 3.
      pwr_up = 1'b1;
      wait_tmr("wait_04", 8'h04, 200);
      sample(16'h0010, 16'h0000, 1'b0);
      chk("ramp4_pid0", 32'(pid0), 32'd3);

      // Reset one edge after a sample is captured kills the pending pulse.
      send(16'h0010, 16'h0000, 1'b0);
      rst = 1'b1;
      tick();
      chk("mid_rst_cv0", 32'(cv0), 32'h0);
      chk("mid_rst_pid0", 32'(pid0), 32'h0);
      chk("mid_rst_tmr0", 32'(tmr0), 32'h0);
      chk("mid_rst_isat0", 32'(isat0), 32'h0);
      chk("mid_rst_state", 32'(u_dut0.state), 32'h0);
      rst = 1'b0;
      tick();
      chk("post_rst_cv0", 32'(cv0), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
